// File: rtl/lbist_pkg.sv
// Shared types for the LBIST response comparator: session FSM states and counter sizing.
package lbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Counters must be able to hold NUM_VEC itself, not just NUM_VEC-1.
    function automatic int cnt_width(input int num_vec);
        return $clog2(num_vec + 1);
    endfunction

endpackage

// File: rtl/lbist_mask_cmp.sv
// Combinational masked compare of one response vector against its expected value.
module lbist_mask_cmp #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] act,
    input  logic [BITS-1:0] exp,
    input  logic [BITS-1:0] mask,
    output logic            mismatch,
    output logic [BITS-1:0] xor_masked
);

    assign xor_masked = (act ^ exp) & ~mask;
    assign mismatch   = |xor_masked;

endmodule

// File: rtl/lbist_resp_cmp.sv
// LBIST session response comparator: FSM, vector/fail counters and registered verdicts.
// Optional first-fail capture (fail_idx/fail_xor) is enabled by defining LBIST_FAIL_CAPTURE_EN.
module lbist_resp_cmp
    import lbist_pkg::*;
#(
    parameter  int BITS    = 8,
    parameter  int NUM_VEC = 16,
    localparam int CNT_W   = cnt_width(NUM_VEC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [BITS-1:0]  act,
    input  logic [BITS-1:0]  exp,
    input  logic [BITS-1:0]  mask,
    output logic             busy,
    output logic             eq_vld,
    output logic             eq,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt
`ifdef LBIST_FAIL_CAPTURE_EN
    ,
    output logic [CNT_W-1:0] fail_idx,
    output logic [BITS-1:0]  fail_xor
`endif
);

    state_t            state;
    logic [CNT_W-1:0]  vec_cnt;
    logic              mismatch;
    logic [BITS-1:0]   xor_masked;
    logic              accept;
    logic              last_vec;
    logic [CNT_W-1:0]  fail_next;

    lbist_mask_cmp #(
        .BITS(BITS)
    ) u_mask_cmp (
        .act        (act),
        .exp        (exp),
        .mask       (mask),
        .mismatch   (mismatch),
        .xor_masked (xor_masked)
    );

    assign accept    = (state == ST_RUN) && in_valid;
    assign last_vec  = (vec_cnt == CNT_W'(NUM_VEC - 1));
    assign fail_next = (mismatch && (fail_cnt != {CNT_W{1'b1}})) ? fail_cnt + CNT_W'(1) : fail_cnt;

    // Verdict of the final vector is folded into pass in the same edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            vec_cnt  <= '0;
            fail_cnt <= '0;
            busy     <= 1'b0;
            eq_vld   <= 1'b0;
            eq       <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            eq_vld <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        vec_cnt  <= '0;
                        fail_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        eq_vld   <= 1'b1;
                        eq       <= ~mismatch;
                        fail_cnt <= fail_next;
                        vec_cnt  <= vec_cnt + CNT_W'(1);
                        if (last_vec) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_next == '0);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LBIST_FAIL_CAPTURE_EN
    // A zero fail count before this vector marks it as the first failure of the session.
    always_ff @(posedge clk) begin
        if (rst || (start && (state != ST_RUN))) begin
            fail_idx <= '0;
            fail_xor <= '0;
        end else if (accept && mismatch && (fail_cnt == '0)) begin
            fail_idx <= vec_cnt;
            fail_xor <= xor_masked;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = accept ^ (^xor_masked);
`endif

endmodule

// File: tb/tb_lbist_resp_cmp.sv
// Directed plus randomized bench for lbist_resp_cmp (BITS=8, NUM_VEC=4) with a vector-level reference model.
module tb_lbist_resp_cmp;

    localparam int BITS    = 8;
    localparam int NUM_VEC = 4;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [BITS-1:0]  act;
    logic [BITS-1:0]  exp;
    logic [BITS-1:0]  mask;
    logic             busy;
    logic             eq_vld;
    logic             eq;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] fail_cnt;
`ifdef LBIST_FAIL_CAPTURE_EN
    logic [CNT_W-1:0] fail_idx;
    logic [BITS-1:0]  fail_xor;
`endif

    int checks   = 0;
    int failures = 0;

    bit        m_active;
    bit        m_done;
    bit        m_pass;
    bit        m_eq_vld;
    bit        m_eq;
    int        m_count;
    int        m_fails;
    int        m_first_idx;
    logic [7:0] m_first_xor;

    lbist_resp_cmp #(
        .BITS    (BITS),
        .NUM_VEC (NUM_VEC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .act      (act),
        .exp      (exp),
        .mask     (mask),
        .busy     (busy),
        .eq_vld   (eq_vld),
        .eq       (eq),
        .done     (done),
        .pass     (pass),
        .fail_cnt (fail_cnt)
`ifdef LBIST_FAIL_CAPTURE_EN
        ,
        .fail_idx (fail_idx),
        .fail_xor (fail_xor)
`endif
    );

    always #5 clk = ~clk;

    // Session-level model: counts accepted vectors and failing ones, bit by bit.
    task automatic modelStep(input bit r, input bit s, input bit v,
                             input logic [7:0] a, input logic [7:0] e, input logic [7:0] m);
        logic [7:0] diff;
        bit         bad;
        m_eq_vld = 1'b0;
        if (r) begin
            m_active = 0; m_done = 0; m_pass = 0; m_count = 0; m_fails = 0;
            m_eq = 0; m_first_idx = 0; m_first_xor = 8'h00;
        end else if (m_active && v) begin
            diff = 8'h00;
            for (int i = 0; i < 8; i++)
                if (!m[i] && (a[i] != e[i])) diff[i] = 1'b1;
            bad      = (diff != 8'h00);
            m_eq_vld = 1'b1;
            m_eq     = !bad;
            if (bad) begin
                if (m_fails == 0) begin
                    m_first_idx = m_count;
                    m_first_xor = diff;
                end
                if (m_fails < 7) m_fails++;
            end
            m_count++;
            if (m_count == NUM_VEC) begin
                m_active = 0;
                m_done   = 1;
                m_pass   = (m_fails == 0);
            end
        end else if (!m_active && s) begin
            m_active = 1; m_done = 0; m_pass = 0; m_count = 0; m_fails = 0;
            m_first_idx = 0; m_first_xor = 8'h00;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("busy", 32'(busy), 32'(m_active));
        checkValue("eq_vld", 32'(eq_vld), 32'(m_eq_vld));
        if (m_eq_vld) checkValue("eq", 32'(eq), 32'(m_eq));
        checkValue("done", 32'(done), 32'(m_done));
        checkValue("pass", 32'(pass), 32'(m_pass));
        checkValue("fail_cnt", 32'(fail_cnt), 32'(m_fails));
`ifdef LBIST_FAIL_CAPTURE_EN
        checkValue("fail_idx", 32'(fail_idx), 32'(m_first_idx));
        checkValue("fail_xor", 32'(fail_xor), 32'(m_first_xor));
`endif
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic applyStimulus(input bit r, input bit s, input bit v,
                                 input logic [7:0] a, input logic [7:0] e, input logic [7:0] m);
        @(negedge clk);
        rst = r; start = s; in_valid = v; act = a; exp = e; mask = m;
        @(posedge clk);
        #1;
        modelStep(r, s, v, a, e, m);
        checkOutput();
    endtask

    task automatic randVec(output logic [7:0] a, output logic [7:0] e, output logic [7:0] m);
        a = 8'($urandom);
        e = ($urandom_range(0, 2) == 0) ? a : (a ^ 8'($urandom));
        case ($urandom_range(0, 3))
            0:       m = 8'h00;
            1:       m = 8'hFF;
            default: m = 8'($urandom);
        endcase
    endtask

    initial begin
        logic [7:0] ra, re, rm;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; act = '0; exp = '0; mask = '0;

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h00);
        applyStimulus(1, 0, 1, 8'hFC, 8'h00, 8'h00);

        $display("[TB] in_valid ignored in IDLE");
        applyStimulus(0, 0, 1, 8'hFC, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 8'h12, 8'h34, 8'h00);

        $display("[TB] all-match session");
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < NUM_VEC; i++)
            applyStimulus(0, 0, 1, 8'hFC, 8'hFC, 8'h00);

        $display("[TB] in_valid ignored in DONE");
        applyStimulus(0, 0, 1, 8'h00, 8'hFF, 8'h00);
        applyStimulus(0, 0, 1, 8'h0F, 8'hF0, 8'h00);

        $display("[TB] mask session");
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 8'hFC, 8'hFF, 8'h03);
        applyStimulus(0, 0, 1, 8'hFC, 8'hFF, 8'h01);
        applyStimulus(0, 0, 1, 8'h5A, 8'hA5, 8'hFF);
        applyStimulus(0, 0, 1, 8'h80, 8'h00, 8'h7F);

        $display("[TB] two fails, gaps, start during RUN");
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 8'hA5, 8'hA5, 8'h00);
        applyStimulus(0, 0, 0, 8'hFF, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 8'hA5, 8'h5A, 8'h0F);
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 8'h33, 8'h33, 8'h00);
        applyStimulus(0, 1, 1, 8'h0F, 8'hF0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 8'h00);

        $display("[TB] reset mid-run");
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 8'h11, 8'h22, 8'h00);
        applyStimulus(0, 0, 1, 8'h44, 8'h44, 8'h00);
        applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h00);
        applyStimulus(0, 0, 1, 8'h11, 8'h22, 8'h00);
        applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < NUM_VEC; i++) begin
            randVec(ra, re, rm);
            applyStimulus(0, 0, 1, ra, re, rm);
        end

        $display("[TB] randomized sessions with restart");
        for (int sess = 0; sess < 25; sess++) begin
            randVec(ra, re, rm);
            applyStimulus(0, 1, $urandom_range(0, 1) == 1, ra, re, rm);
            for (int k = 0; k < 200 && m_active; k++) begin
                randVec(ra, re, rm);
                applyStimulus(0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, ra, re, rm);
            end
            if ($urandom_range(0, 2) == 0) begin
                randVec(ra, re, rm);
                applyStimulus(0, 0, 1, ra, re, rm);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
